// File: rtl/mesi_isc_seq_pkg.sv
// rtl/mesi_isc_seq_pkg.sv - shared types for the MESI ISC broadcast sequencer
// Contents: CPU count, main-bus and coherence-bus command encodings, sequencer states.
package mesi_isc_seq_pkg;

  localparam int CPU_NUM = 4;

  typedef enum logic [2:0] {
    MBUS_NOP      = 3'd0,
    MBUS_WR       = 3'd1,
    MBUS_RD       = 3'd2,
    MBUS_WR_BROAD = 3'd3,
    MBUS_RD_BROAD = 3'd4
  } mbus_cmd_e;

  typedef enum logic [2:0] {
    CBUS_NOP      = 3'd0,
    CBUS_WR_SNOOP = 3'd1,
    CBUS_RD_SNOOP = 3'd2,
    CBUS_EN_WR    = 3'd3,
    CBUS_EN_RD    = 3'd4
  } cbus_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SNOOP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_ACK    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mesi_isc_rr_arb4.sv
// rtl/mesi_isc_rr_arb4.sv - combinational 4-way round-robin picker
// Ports:
//   req    in   4  request lines, one per CPU
//   ptr    in   2  highest-priority CPU this cycle
//   gnt_id out  2  first requester at or after ptr (mod 4)
//   valid  out  1  at least one request present
module mesi_isc_rr_arb4
  import mesi_isc_seq_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_id,
  output logic       valid
);

  logic [1:0] idx;

  // Scan from the farthest offset down to ptr itself so the nearest
  // requester is the last one written and therefore wins.
  always_comb begin
    gnt_id = ptr;
    valid  = |req;
    idx    = '0;
    for (int k = CPU_NUM - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) gnt_id = idx;
    end
  end

endmodule

// File: rtl/mesi_isc_bcast_seq.sv
// rtl/mesi_isc_bcast_seq.sv - coherence-bus broadcast sequencer for 4 CPU caches
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   mbus_cmd_i    per-CPU main-bus command (CPU n at [n*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH])
//   mbus_addr_i   per-CPU main-bus address
//   mbus_ack_o    one-cycle completion pulse to the requester
//   cbus_cmd_o    per-CPU coherence command
//   cbus_addr_o   shared coherence address of the running transaction
//   cbus_ack_i    per-CPU coherence acknowledge
//   busy_o        transaction in progress
//   owner_o       id of current or last requester
//   timeout_o     one-cycle pulse when a wait state is aborted by the watchdog
module mesi_isc_bcast_seq
  import mesi_isc_seq_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          MBUS_CMD_WIDTH = 3,
  parameter int          CBUS_CMD_WIDTH = 3,
  parameter int unsigned TIMEOUT_CYC    = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CPU_NUM*MBUS_CMD_WIDTH-1:0]   mbus_cmd_i,
  input  logic [CPU_NUM*ADDR_WIDTH-1:0]       mbus_addr_i,
  output logic [CPU_NUM-1:0]                  mbus_ack_o,
  output logic [CPU_NUM*CBUS_CMD_WIDTH-1:0]   cbus_cmd_o,
  output logic [ADDR_WIDTH-1:0]               cbus_addr_o,
  input  logic [CPU_NUM-1:0]                  cbus_ack_i,
  output logic                                busy_o,
  output logic [1:0]                          owner_o,
  output logic                                timeout_o
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);
  localparam logic        TIMEOUT_EN  = (TIMEOUT_CYC != 0);

  seq_state_e state_q, state_d;
  logic [1:0]             rr_ptr_q;
  logic                   wr_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [CPU_NUM-1:0]     ack_mask_q;
  logic [15:0]            timer_q;

  logic [MBUS_CMD_WIDTH-1:0] cmd_arr  [CPU_NUM];
  logic [ADDR_WIDTH-1:0]     addr_arr [CPU_NUM];
  logic [CPU_NUM-1:0]        req;
  logic [1:0]                gnt_id;
  logic                      gnt_valid;
  logic [CPU_NUM-1:0]        owner_bit;
  logic [CPU_NUM-1:0]        ack_mask_nxt;
  logic                      snoop_done;
  logic                      timer_hit;

  always_comb begin
    req = '0;
    for (int i = 0; i < CPU_NUM; i++) begin
      cmd_arr[i]  = mbus_cmd_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
      addr_arr[i] = mbus_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      req[i]      = (cmd_arr[i] == MBUS_CMD_WIDTH'(MBUS_WR_BROAD)) ||
                    (cmd_arr[i] == MBUS_CMD_WIDTH'(MBUS_RD_BROAD));
    end
  end

  mesi_isc_rr_arb4 u_arb (
    .req    (req),
    .ptr    (rr_ptr_q),
    .gnt_id (gnt_id),
    .valid  (gnt_valid)
  );

  // The owner's own ack never counts toward the snoop phase; forcing its bit
  // on lets one AND-reduce detect "all three others have answered".
  assign owner_bit    = 4'b0001 << owner_q_w();
  assign ack_mask_nxt = ack_mask_q | (cbus_ack_i & ~owner_bit);
  assign snoop_done   = &(ack_mask_nxt | owner_bit);
  assign timer_hit    = TIMEOUT_EN && (timer_q == TIMEOUT_LIM);

  function automatic logic [1:0] owner_q_w();
    return owner_o;
  endfunction

  always_comb begin
    state_d     = state_q;
    mbus_ack_o  = '0;
    cbus_cmd_o  = '0;
    timeout_o   = 1'b0;
    busy_o      = (state_q != ST_IDLE);
    cbus_addr_o = (state_q != ST_IDLE) ? addr_q : '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) state_d = ST_SNOOP;
      end
      ST_SNOOP: begin
        if (timer_hit) begin
          timeout_o = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          for (int i = 0; i < CPU_NUM; i++) begin
            if ((2'(i) != owner_o) && !ack_mask_q[i])
              cbus_cmd_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
                wr_q ? CBUS_CMD_WIDTH'(CBUS_WR_SNOOP) : CBUS_CMD_WIDTH'(CBUS_RD_SNOOP);
          end
          if (snoop_done) state_d = ST_ENABLE;
        end
      end
      ST_ENABLE: begin
        if (timer_hit) begin
          timeout_o = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          for (int i = 0; i < CPU_NUM; i++) begin
            if (2'(i) == owner_o)
              cbus_cmd_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
                wr_q ? CBUS_CMD_WIDTH'(CBUS_EN_WR) : CBUS_CMD_WIDTH'(CBUS_EN_RD);
          end
          if (cbus_ack_i[owner_o]) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        mbus_ack_o = owner_bit;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_o    <= '0;
      rr_ptr_q   <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      ack_mask_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_o    <= gnt_id;
            rr_ptr_q   <= gnt_id + 2'd1;
            wr_q       <= (cmd_arr[gnt_id] == MBUS_CMD_WIDTH'(MBUS_WR_BROAD));
            addr_q     <= addr_arr[gnt_id];
            ack_mask_q <= '0;
            timer_q    <= '0;
          end
        end
        ST_SNOOP: begin
          ack_mask_q <= (state_d == ST_IDLE) ? '0 : ack_mask_nxt;
          timer_q    <= (state_d == ST_ENABLE) ? 16'd0 : timer_q + 16'd1;
        end
        ST_ENABLE: begin
          if (state_d == ST_IDLE) ack_mask_q <= '0;
          timer_q <= timer_q + 16'd1;
        end
        default: begin
          ack_mask_q <= '0;
        end
      endcase
    end
  end

endmodule
